// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between the instruction-fetch port
// and the load/store data port. Data requests win by default; a starvation
// counter guarantees fetch a grant after MAX_D_BURST consecutive data grants
// while it waits. Read data returns one cycle after the grant and is steered
// to the port that issued the read.
module mem_arbiter #(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_adrs,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_adrs,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_adrs,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    input  logic [31:0] ram_q
);

    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_LOAD  = 2'd2
    } rsp_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);

    logic [3:0] starve_cnt_r;
    rsp_t       rsp_src_r;
    logic       i_gnt_s;
    logic       d_gnt_s;

    // Arbitration: data first unless fetch has already waited MAX_D_BURST grants.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (reset) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (d_req && !(i_req && (starve_cnt_r >= MAX_CNT))) begin
            d_gnt_s = 1'b1;
        end else if (i_req) begin
            i_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    assign i_gnt = i_gnt_s;
    assign d_gnt = d_gnt_s;

    // Count data grants taken while fetch waits; saturate at the burst limit.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else if (i_gnt_s || !i_req) begin
            starve_cnt_r <= 4'd0;
        end else if (d_gnt_s && (starve_cnt_r < MAX_CNT)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Remember which port owns the read data arriving next cycle.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            rsp_src_r <= RSP_NONE;
        end else if (i_gnt_s) begin
            rsp_src_r <= RSP_FETCH;
        end else if (d_gnt_s && !d_wr) begin
            rsp_src_r <= RSP_LOAD;
        end else begin
            rsp_src_r <= RSP_NONE;
        end
    end

    // Drive the RAM command from whichever port holds the grant.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_adrs  = 32'd0;
        ram_wdata = 32'd0;
        ram_be    = 4'd0;
        case ({d_gnt_s, i_gnt_s})
            2'b10: begin
                ram_en    = 1'b1;
                ram_we    = d_wr;
                ram_adrs  = d_adrs;
                ram_wdata = d_wdata;
                ram_be    = d_be;
            end
            2'b01: begin
                ram_en    = 1'b1;
                ram_we    = 1'b0;
                ram_adrs  = i_adrs;
                ram_wdata = 32'd0;
                ram_be    = 4'hf;
            end
            default: begin
                ram_en    = 1'b0;
                ram_we    = 1'b0;
                ram_adrs  = 32'd0;
                ram_wdata = 32'd0;
                ram_be    = 4'd0;
            end
        endcase
    end

    // Steer returning read data; any response in flight is dropped while reset is held.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        if (reset) begin
            i_rvalid = 1'b0;
            d_rvalid = 1'b0;
        end else begin
            i_rvalid = (rsp_src_r == RSP_FETCH);
            d_rvalid = (rsp_src_r == RSP_LOAD);
        end
        i_rdata = i_rvalid ? ram_q : 32'd0;
        d_rdata = d_rvalid ? ram_q : 32'd0;
    end

endmodule
